// File: rtl/wave_sample_gen_pkg.sv
// Shared encodings for the waveform generator and the DAC sequencer side.
// Sample width, midscale, wave selects, FSM states, attenuation helper.
package wave_sample_gen_pkg;

    localparam int          DATA_W   = 12;
    localparam logic [11:0] MIDSCALE = 12'h800;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_SAW    = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_SINE   = 2'b11
    } wave_sel_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_SHAPE = 2'b10,
        S_OFFER = 2'b11
    } state_e;

    // Arithmetic shift of the signed offset from midscale, then re-bias.
    function automatic logic [11:0] attenuate(
        input logic [11:0] v,
        input logic [2:0]  sh
    );
        logic signed [12:0] s;
        s = $signed({1'b0, v}) - 13'sd2048;
        s = s >>> sh;
        return 12'(s + 13'sd2048);
    endfunction

endpackage

// File: rtl/wave_sample_gen_if.sv
// Sample stream towards the DAC SPI sequencer.
// The sequencer answers each latched word with a one-cycle ready pulse.
interface wave_sample_gen_if;
    import wave_sample_gen_pkg::*;

    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/wave_sine_rom.sv
// Quarter-wave sine table (256 x 11 bit) with mirroring and negation.
// The generator's sample register captures the read, so it acts as the ROM register.
module wave_sine_rom
    import wave_sample_gen_pkg::*;
(
    input  logic [11:2] p_i,
    output logic [11:0] sine_o
);

    // Bhaskara approximation of 2047*sin(90deg * a/255), rounded.
    function automatic int sine_val(input int a);
        int u;
        int den;
        u   = a * (510 - a);
        den = 325125 - u;
        return (2047 * 4 * u + den / 2) / den;
    endfunction

    logic [10:0] rom [256];
    logic [7:0]  addr;
    logic [11:0] mag;

    for (genvar g = 0; g < 256; g++) begin : g_rom
        assign rom[g] = 11'(sine_val(g));
    end

    assign addr   = p_i[10] ? ~p_i[9:2] : p_i[9:2];
    assign mag    = {1'b0, rom[addr]};
    assign sine_o = p_i[11] ? (MIDSCALE - mag) : (MIDSCALE + mag);

endmodule

// File: rtl/wave_sample_gen.sv
// Phase-accumulator waveform generator with valid/ready sample output.
// Optional sine shape via WAVE_SINE_LUT_EN; otherwise select 11 is DC midscale.
module wave_sample_gen #(
    parameter int ACC_W      = 24,
    parameter int SAMPLE_DIV = 1000,
    parameter int DATA_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] freq_word,
    input  logic [1:0]       wave_sel,
    input  logic [2:0]       atten,
    input  logic             clr_overrun,
    output logic             overrun,
    wave_sample_gen_if.master smp
);
    import wave_sample_gen_pkg::*;

    localparam int             CNT_W    = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  phase_q, phase_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              over_q, over_d;
    logic              tick;
    logic [11:0]       p;
    logic [11:0]       shaped;
    logic [11:0]       sine_w;

    assign tick = en && (cnt_q == CNT_LAST);
    assign p    = phase_q[ACC_W-1 -: 12];

`ifdef WAVE_SINE_LUT_EN
    wave_sine_rom u_sine_rom (
        .p_i    (p[11:2]),
        .sine_o (sine_w)
    );
`else
    assign sine_w = MIDSCALE;
`endif

    always_comb begin
        shaped = MIDSCALE;
        unique case (wave_sel_e'(wave_sel))
            WAVE_SQUARE: shaped = p[11] ? 12'hFFF : 12'h000;
            WAVE_SAW:    shaped = p;
            WAVE_TRI:    shaped = p[11] ? ~{p[10:0], 1'b0}
                                        :  {p[10:0], 1'b0};
            WAVE_SINE:   shaped = sine_w;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        sample_d = sample_q;
        over_d   = clr_overrun ? 1'b0 : over_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick) begin
                    phase_d = phase_q + freq_word;
                    state_d = S_SHAPE;
                end
            end
            S_SHAPE: begin
                sample_d = attenuate(shaped, atten);
                state_d  = S_OFFER;
            end
            S_OFFER: begin
                // A tick here still advances phase; acceptance beats overrun.
                if (tick) phase_d = phase_q + freq_word;
                if (smp.sample_ready) state_d = S_WAIT;
                else if (tick)        over_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (!en) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            phase_d  = phase_q;
            sample_d = sample_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            phase_q  <= '0;
            sample_q <= MIDSCALE;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            over_q   <= over_d;
        end
    end

    assign smp.sample       = sample_q;
    assign smp.sample_valid = (state_q == S_OFFER);
    assign overrun          = over_q;

endmodule

// File: tb/tb_wave_sample_gen.sv
// Bench for wave_sample_gen: vector table, handshake sequences, randomized model run.
// Builds with or without WAVE_SINE_LUT_EN.
`timescale 1ns/1ps
module tb_wave_sample_gen;

    localparam int ACC_W = 24;
    localparam int DIV   = 4;
`ifdef WAVE_SINE_LUT_EN
    localparam bit SINE = 1'b1;
`else
    localparam bit SINE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [ACC_W-1:0] freq_word;
    logic [1:0]       wave_sel;
    logic [2:0]       atten;
    logic             clr_overrun;
    logic             overrun;

    wave_sample_gen_if smp ();

    wave_sample_gen #(
        .ACC_W      (ACC_W),
        .SAMPLE_DIV (DIV),
        .DATA_W     (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .freq_word   (freq_word),
        .wave_sel    (wave_sel),
        .atten       (atten),
        .clr_overrun (clr_overrun),
        .overrun     (overrun),
        .smp         (smp.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp, int tol);
        int d;
        checks++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)",
                         name, act, exp, tol);
        end
    endfunction

    // Reference: top 12 phase bits shaped by plain arithmetic, then
    // attenuated as a floor division of the offset from midscale.
    function automatic int ref_sample(longint ph, int ws, int at);
        int  p;
        int  sh;
        int  s;
        real th;
        p = int'((ph % (longint'(1) << ACC_W)) / (longint'(1) << (ACC_W - 12)));
        case (ws)
            0: sh = (p >= 2048) ? 4095 : 0;
            1: sh = p;
            2: sh = (p < 2048) ? 2 * p : 4095 - 2 * (p - 2048);
            default: begin
                th = 2.0 * 3.14159265358979 * real'(p) / 4096.0;
                sh = SINE ? 2048 + int'($floor(2047.0 * $sin(th) + 0.5)) : 2048;
            end
        endcase
        s = sh - 2048;
        return 2048 + int'($floor(real'(s) / real'(1 << at)));
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        clr_overrun = 1'b0;
        smp.sample_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            cyc();
            if (smp.sample_valid) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  ws;
        logic [2:0]  at;
        logic [23:0] fw;
        int          exp;
        int          tol;
    } vec_t;

    vec_t vt [12];

    // Free-running accept with ready pulsed one cycle after each valid.
    task automatic run_seq(input int ws, input int at, input logic [23:0] fw,
                           input int ns, input string nm);
        int n;
        int tol;
        tol = (ws == 3 && SINE) ? 1 : 0;
        do_reset();
        wave_sel = 2'(ws);
        atten = 3'(at);
        freq_word = fw;
        en = 1'b1;
        for (int i = 0; i < ns; i++) begin
            wait_valid(3 * DIV + 4, n);
            chk($sformatf("%s lat%0d", nm, i), n, (i == 0) ? DIV + 1 : DIV - 2, 0);
            if (n < 0) break;
            chk($sformatf("%s s%0d", nm, i), int'(smp.sample),
                ref_sample(longint'(i + 1) * longint'(fw), ws, at), tol);
            cyc();
            chk($sformatf("%s hold%0d", nm, i), int'(smp.sample_valid), 1, 0);
            smp.sample_ready = 1'b1;
            cyc();
            smp.sample_ready = 1'b0;
            chk($sformatf("%s drop%0d", nm, i), int'(smp.sample_valid), 0, 0);
        end
        en = 1'b0;
    endtask

    task automatic rand_seg(input int ncyc, input int seg);
        logic [23:0] fw;
        int ws, at, pr, tol, cd, es;
        longint nt;
        bit waiting, ev, eo, tick, rdy, clr, set_o;
        fw = 24'($urandom);
        ws = $urandom_range(0, 3);
        at = $urandom_range(0, 7);
        pr = $urandom_range(1, 5);
        tol = (ws == 3 && SINE) ? 16 : 0;
        do_reset();
        freq_word = fw;
        wave_sel = 2'(ws);
        atten = 3'(at);
        en = 1'b1;
        nt = 0;
        waiting = 1'b1;
        ev = 1'b0;
        eo = 1'b0;
        cd = 0;
        es = 2048;
        for (int c = 0; c < ncyc; c++) begin
            chk($sformatf("rnd%0d valid c%0d", seg, c), int'(smp.sample_valid), int'(ev), 0);
            chk($sformatf("rnd%0d ovr c%0d", seg, c), int'(overrun), int'(eo), 0);
            if (ev)
                chk($sformatf("rnd%0d smp c%0d", seg, c), int'(smp.sample), es, tol);
            rdy = ($urandom_range(0, pr) == 0);
            clr = ($urandom_range(0, 15) == 0);
            smp.sample_ready = rdy;
            clr_overrun = clr;
            tick = ((c % DIV) == DIV - 1);
            if (tick) nt++;
            set_o = 1'b0;
            if (ev) begin
                if (rdy) begin
                    ev = 1'b0;
                    waiting = 1'b1;
                end else if (tick) begin
                    set_o = 1'b1;
                end
            end else if (cd != 0) begin
                cd = 0;
                ev = 1'b1;
            end else if (waiting && tick) begin
                waiting = 1'b0;
                cd = 1;
                es = ref_sample(nt * longint'(fw), ws, at);
            end
            eo = set_o ? 1'b1 : (clr ? 1'b0 : eo);
            cyc();
        end
        smp.sample_ready = 1'b0;
        clr_overrun = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        en = 1'b0;
        clr_overrun = 1'b0;
        smp.sample_ready = 1'b0;
        freq_word = '0;
        wave_sel = 2'd1;
        atten = 3'd0;
        cyc();
        chk("rst valid", int'(smp.sample_valid), 0, 0);
        chk("rst sample", int'(smp.sample), 12'h800, 0);
        chk("rst overrun", int'(overrun), 0, 0);

        vt[0]  = '{2'd1, 3'd0, 24'h100000, 12'h100, 0};
        vt[1]  = '{2'd1, 3'd1, 24'h100000, 12'h480, 0};
        vt[2]  = '{2'd1, 3'd7, 24'h100000, 12'h7F2, 0};
        vt[3]  = '{2'd0, 3'd0, 24'h400000, 12'h000, 0};
        vt[4]  = '{2'd2, 3'd0, 24'h400000, 12'h800, 0};
        vt[5]  = '{2'd0, 3'd0, 24'hC00000, 12'hFFF, 0};
        vt[6]  = '{2'd2, 3'd0, 24'h200000, 12'h400, 0};
        vt[7]  = '{2'd2, 3'd2, 24'hC00000, 12'h7FF, 0};
        vt[8]  = '{2'd1, 3'd3, 24'hFFF000, 12'h8FF, 0};
        vt[9]  = '{2'd0, 3'd4, 24'h800000, 12'h87F, 0};
        vt[10] = '{2'd3, 3'd0, 24'h400000, SINE ? 12'hFFF : 12'h800, SINE ? 1 : 0};
        vt[11] = '{2'd1, 3'd0, 24'h000800, 12'h000, 0};

        for (int i = 0; i < 12; i++) begin
            do_reset();
            wave_sel = vt[i].ws;
            atten = vt[i].at;
            freq_word = vt[i].fw;
            en = 1'b1;
            wait_valid(4 * DIV, n);
            chk($sformatf("vec%0d latency", i), n, DIV + 1, 0);
            chk($sformatf("vec%0d sample", i), int'(smp.sample), vt[i].exp, vt[i].tol);
            en = 1'b0;
        end

        run_seq(1, 0, 24'h100000, 16, "saw");
        run_seq(0, 0, 24'h400000, 8, "square");
        run_seq(2, 0, 24'h400000, 4, "tri");
        run_seq(3, 0, 24'h400000, 4, "sel11");
        run_seq(1, 5, 24'h3A5000, 6, "saw_att5");

        // Overrun: hold ready low across a tick, then clear / set collisions.
        do_reset();
        wave_sel = 2'd1;
        atten = 3'd0;
        freq_word = 24'h100000;
        en = 1'b1;
        wait_valid(4 * DIV, n);
        chk("ovr first", int'(smp.sample), 12'h100, 0);
        cyc();
        cyc();
        chk("ovr before tick", int'(overrun), 0, 0);
        cyc();
        chk("ovr set", int'(overrun), 1, 0);
        chk("ovr valid held", int'(smp.sample_valid), 1, 0);
        chk("ovr sample held", int'(smp.sample), 12'h100, 0);
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;
        chk("ovr cleared", int'(overrun), 0, 0);
        smp.sample_ready = 1'b1;
        cyc();
        smp.sample_ready = 1'b0;
        chk("ovr accept drop", int'(smp.sample_valid), 0, 0);
        wait_valid(4 * DIV, n);
        chk("ovr next sample", int'(smp.sample), 12'h300, 0);
        chk("ovr next flag", int'(overrun), 0, 0);
        cyc();
        cyc();
        clr_overrun = 1'b1;
        cyc();
        chk("ovr set beats clr", int'(overrun), 1, 0);
        cyc();
        clr_overrun = 1'b0;
        chk("ovr clr again", int'(overrun), 0, 0);
        cyc();
        cyc();
        smp.sample_ready = 1'b1;
        cyc();
        smp.sample_ready = 1'b0;
        chk("ovr ready+tick valid", int'(smp.sample_valid), 0, 0);
        chk("ovr ready+tick flag", int'(overrun), 0, 0);
        wait_valid(4 * DIV, n);
        chk("ovr lost tick sample", int'(smp.sample), 12'h600, 0);
        chk("ovr lost tick flag", int'(overrun), 0, 0);
        en = 1'b0;

        // Reset and enable drop while a sample is offered.
        do_reset();
        wave_sel = 2'd1;
        atten = 3'd0;
        freq_word = 24'h100000;
        en = 1'b1;
        wait_valid(4 * DIV, n);
        chk("rst5 pre", int'(smp.sample), 12'h100, 0);
        rst = 1'b1;
        #1;
        chk("rst5 valid", int'(smp.sample_valid), 0, 0);
        chk("rst5 sample", int'(smp.sample), 12'h800, 0);
        cyc();
        rst = 1'b0;
        wait_valid(4 * DIV, n);
        chk("rst5 latency", n, DIV + 1, 0);
        chk("rst5 after", int'(smp.sample), 12'h100, 0);
        en = 1'b0;
        cyc();
        chk("en drop valid", int'(smp.sample_valid), 0, 0);
        chk("en drop sample", int'(smp.sample), 12'h100, 0);
        cyc();
        en = 1'b1;
        wait_valid(4 * DIV, n);
        chk("en resume latency", n, DIV + 1, 0);
        chk("en resume sample", int'(smp.sample), 12'h200, 0);
        en = 1'b0;

        for (int s = 0; s < 10; s++) rand_seg(300, s);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
